// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALU-op and per-stage control bundle definitions for the pipelined control unit.
package pipe_ctrl_pkg;

   localparam int OPC_W = 6;
   localparam int RA_W  = 5;
   localparam int AOP_W = 2;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

   localparam logic [AOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [AOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [AOP_W-1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic             illegal;
      logic             alu_src;
      logic [AOP_W-1:0] alu_op;
   } ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
   } mem_ctrl_t;

   typedef struct packed {
      logic            mem_to_reg;
      logic            reg_write;
      logic [RA_W-1:0] wr_reg;
   } wb_ctrl_t;

   localparam ex_ctrl_t  EX_BUBBLE  = '0;
   localparam mem_ctrl_t MEM_BUBBLE = '0;
   localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-bundle decode; zero latency, no flow control.
// Invalid slots and unknown opcodes produce an all-zero bundle; unknown opcodes also raise the illegal bit.
module ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic             id_valid,
   input  logic [OPC_W-1:0] id_opcode,
   input  logic [RA_W-1:0]  id_rt,
   input  logic [RA_W-1:0]  id_rd,
   output ex_ctrl_t         ex_o,
   output mem_ctrl_t        mem_o,
   output wb_ctrl_t         wb_o,
   output logic             uses_rt_o
);

   logic regdst;

   always_comb begin
      ex_o      = EX_BUBBLE;
      mem_o     = MEM_BUBBLE;
      wb_o      = WB_BUBBLE;
      uses_rt_o = 1'b0;
      regdst    = 1'b0;
      if (id_valid) begin
         case (id_opcode)
            OP_RTYPE: begin
               regdst         = 1'b1;
               wb_o.reg_write = 1'b1;
               ex_o.alu_op    = ALUOP_FUNCT;
               uses_rt_o      = 1'b1;
            end
            OP_LW: begin
               ex_o.alu_src    = 1'b1;
               ex_o.alu_op     = ALUOP_ADD;
               mem_o.mem_read  = 1'b1;
               wb_o.mem_to_reg = 1'b1;
               wb_o.reg_write  = 1'b1;
            end
            OP_SW: begin
               ex_o.alu_src    = 1'b1;
               ex_o.alu_op     = ALUOP_ADD;
               mem_o.mem_write = 1'b1;
               uses_rt_o       = 1'b1;
            end
            OP_BEQ: begin
               ex_o.alu_op  = ALUOP_SUB;
               mem_o.branch = 1'b1;
               uses_rt_o    = 1'b1;
            end
            OP_ADDI: begin
               ex_o.alu_src   = 1'b1;
               ex_o.alu_op    = ALUOP_ADD;
               wb_o.reg_write = 1'b1;
            end
            default: ex_o.illegal = 1'b1;
         endcase
         // Non-writing instructions carry register 0 so later stages never see a stale target.
         if (wb_o.reg_write)
            wb_o.wr_reg = regdst ? id_rd : id_rt;
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS main control: decode in ID, carry bundles through ID/EX, EX/MEM, MEM/WB (ex +1, mem +2, wb +3 cycles).
// stall_in freezes all stages, flush_in zeroes ID/EX and EX/MEM; load-use bubbles only when LOAD_USE_DETECT_EN is defined.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int OPCODE_W = OPC_W,
   parameter int REG_AW   = RA_W,
   parameter int ALUOP_W  = AOP_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [OPCODE_W-1:0] id_opcode,
   input  logic [REG_AW-1:0]   id_rs,
   input  logic [REG_AW-1:0]   id_rt,
   input  logic [REG_AW-1:0]   id_rd,
   input  logic                stall_in,
   input  logic                flush_in,
   output logic                hazard_stall,
   output logic                ex_alu_src,
   output logic [ALUOP_W-1:0]  ex_alu_op,
   output logic [REG_AW-1:0]   ex_wr_reg,
   output logic                mem_branch,
   output logic                mem_read,
   output logic                mem_write,
   output logic                wb_mem_to_reg,
   output logic                wb_reg_write,
   output logic [REG_AW-1:0]   wb_wr_reg,
   output logic                illegal_op
);

   ex_ctrl_t  dec_ex;
   mem_ctrl_t dec_mem;
   wb_ctrl_t  dec_wb;
   logic      dec_uses_rt;
   logic      hazard;

   ex_ctrl_t  idex_ex_q,   idex_ex_d;
   mem_ctrl_t idex_mem_q,  idex_mem_d;
   wb_ctrl_t  idex_wb_q,   idex_wb_d;
   mem_ctrl_t exmem_mem_q, exmem_mem_d;
   wb_ctrl_t  exmem_wb_q,  exmem_wb_d;
   wb_ctrl_t  memwb_wb_q,  memwb_wb_d;

   ctrl_decode u_decode (
      .id_valid  (id_valid),
      .id_opcode (id_opcode),
      .id_rt     (id_rt),
      .id_rd     (id_rd),
      .ex_o      (dec_ex),
      .mem_o     (dec_mem),
      .wb_o      (dec_wb),
      .uses_rt_o (dec_uses_rt)
   );

`ifdef LOAD_USE_DETECT_EN
   // The load sitting in ID/EX cannot forward in time for a dependent instruction in ID.
   always_comb begin
      hazard = ~flush_in & id_valid & idex_mem_q.mem_read & (idex_wb_q.wr_reg != '0)
             & ((idex_wb_q.wr_reg == id_rs) | (dec_uses_rt & (idex_wb_q.wr_reg == id_rt)));
   end
`else
   logic unused_hazard_inputs;
   assign unused_hazard_inputs = ^{id_rs, dec_uses_rt};
   assign hazard = 1'b0;
`endif

   always_comb begin
      idex_ex_d   = idex_ex_q;
      idex_mem_d  = idex_mem_q;
      idex_wb_d   = idex_wb_q;
      exmem_mem_d = exmem_mem_q;
      exmem_wb_d  = exmem_wb_q;
      memwb_wb_d  = memwb_wb_q;
      if (flush_in) begin
         idex_ex_d   = EX_BUBBLE;
         idex_mem_d  = MEM_BUBBLE;
         idex_wb_d   = WB_BUBBLE;
         exmem_mem_d = MEM_BUBBLE;
         exmem_wb_d  = WB_BUBBLE;
         if (!stall_in)
            memwb_wb_d = exmem_wb_q;
      end else if (!stall_in) begin
         if (hazard) begin
            idex_ex_d  = EX_BUBBLE;
            idex_mem_d = MEM_BUBBLE;
            idex_wb_d  = WB_BUBBLE;
         end else begin
            idex_ex_d  = dec_ex;
            idex_mem_d = dec_mem;
            idex_wb_d  = dec_wb;
         end
         exmem_mem_d = idex_mem_q;
         exmem_wb_d  = idex_wb_q;
         memwb_wb_d  = exmem_wb_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_ex_q   <= EX_BUBBLE;
         idex_mem_q  <= MEM_BUBBLE;
         idex_wb_q   <= WB_BUBBLE;
         exmem_mem_q <= MEM_BUBBLE;
         exmem_wb_q  <= WB_BUBBLE;
         memwb_wb_q  <= WB_BUBBLE;
      end else begin
         idex_ex_q   <= idex_ex_d;
         idex_mem_q  <= idex_mem_d;
         idex_wb_q   <= idex_wb_d;
         exmem_mem_q <= exmem_mem_d;
         exmem_wb_q  <= exmem_wb_d;
         memwb_wb_q  <= memwb_wb_d;
      end
   end

   assign hazard_stall  = hazard;
   assign ex_alu_src    = idex_ex_q.alu_src;
   assign ex_alu_op     = idex_ex_q.alu_op;
   assign ex_wr_reg     = idex_wb_q.wr_reg;
   assign illegal_op    = idex_ex_q.illegal;
   assign mem_branch    = exmem_mem_q.branch;
   assign mem_read      = exmem_mem_q.mem_read;
   assign mem_write     = exmem_mem_q.mem_write;
   assign wb_mem_to_reg = memwb_wb_q.mem_to_reg;
   assign wb_reg_write  = memwb_wb_q.reg_write;
   assign wb_wr_reg     = memwb_wb_q.wr_reg;

endmodule
